// File: rtl/baud_pkg.sv
// Shared types and constants for the baud-rate generator and receive timing engine.
package baud_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DIV_MIN = 2;

  // Standard divisors for the 50 MHz board clock.
  localparam int BOARD_CLK_HZ = 50_000_000;
  localparam int DIV_9600     = BOARD_CLK_HZ / 9600;
  localparam int DIV_19200    = BOARD_CLK_HZ / 19200;
  localparam int DIV_115200   = BOARD_CLK_HZ / 115200;

endpackage

// File: rtl/baud_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input, with an optional
// 3-tap majority glitch filter selected by BAUD_GEN_RX_FILTER_EN.
module baud_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rxd,
  output logic o_rxd_c
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
    end
  end

`ifdef BAUD_GEN_RX_FILTER_EN
  logic [1:0] r_tap;
  logic       r_maj;
  logic       w_maj;

  // A lone low sample never wins the vote, so one-cycle glitches are absorbed.
  assign w_maj = (r_sync[1] & r_tap[0]) | (r_sync[1] & r_tap[1]) | (r_tap[0] & r_tap[1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tap <= 2'b11;
      r_maj <= 1'b1;
    end else begin
      r_tap <= {r_tap[0], r_sync[1]};
      r_maj <= w_maj;
    end
  end

  assign o_rxd_c = r_maj;
`else
  assign o_rxd_c = r_sync[1];
`endif

endmodule

// File: rtl/baud_gen.sv
// Baud-rate generator with loadable divisor plus start-edge resynchronised receive
// bit timing. Optional input glitch filter: define BAUD_GEN_RX_FILTER_EN.
module baud_gen
  import baud_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DIV_RST   = 5208,
  parameter int DATA_BITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_load,
  input  logic             i_rxd,
  output logic             o_tx_tick,
  output logic             o_clk_bps,
  output logic             o_rx_busy,
  output logic             o_rx_tick,
  output logic             o_rx_bit,
  output logic             o_frame_done,
  output logic             o_frame_err
);

  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_div_last;
  logic [CNT_W-1:0] w_half_last;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] w_tx_cnt_nxt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] w_rx_cnt_nxt;
  logic [3:0]       r_bit_idx;
  logic [3:0]       w_bit_idx_nxt;
  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic             w_rxd_c;
  logic             r_rxd_d;
  logic             w_fall;
  logic             w_tx_tick_nxt;
  logic             w_clk_bps_nxt;
  logic             w_rx_tick_nxt;
  logic             w_stop_nxt;
  logic             r_tx_tick;
  logic             r_clk_bps;
  logic             r_rx_busy;
  logic             r_rx_tick;
  logic             r_rx_bit;
  logic             r_frame_done;
  logic             r_frame_err;

  baud_rx_sync u_rx_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rxd   (i_rxd),
    .o_rxd_c (w_rxd_c)
  );

  assign w_fall      = r_rxd_d & ~w_rxd_c;
  assign w_div_last  = r_div_q - CNT_W'(1);
  assign w_half_last = (r_div_q >> 1) - CNT_W'(1);

  always_comb begin
    w_div_nxt    = r_div_q;
    w_tx_cnt_nxt = r_tx_cnt;
    if (i_div_load) begin
      w_div_nxt    = (i_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : i_div;
      w_tx_cnt_nxt = '0;
    end else if (i_en) begin
      w_tx_cnt_nxt = (r_tx_cnt >= w_div_last) ? '0 : r_tx_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from next-state values so each pulse lines up with
  // the cycle in which its counter sits at the terminal count.
  assign w_tx_tick_nxt = i_en && !i_div_load && (w_tx_cnt_nxt == w_div_nxt - CNT_W'(1));
  assign w_clk_bps_nxt = w_tx_cnt_nxt < (w_div_nxt >> 1);

  always_comb begin
    w_state_nxt   = r_state;
    w_rx_cnt_nxt  = r_rx_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    if (i_div_load || !i_en) begin
      w_state_nxt   = IDLE;
      w_rx_cnt_nxt  = '0;
      w_bit_idx_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_rx_cnt_nxt = '0;
          if (w_fall) begin
            w_state_nxt = START;
          end
        end
        START: begin
          if (r_rx_cnt == w_half_last) begin
            w_rx_cnt_nxt  = '0;
            w_bit_idx_nxt = '0;
            w_state_nxt   = w_rxd_c ? IDLE : DATA;
          end
        end
        DATA: begin
          if (r_rx_cnt == w_div_last) begin
            w_rx_cnt_nxt  = '0;
            w_bit_idx_nxt = r_bit_idx + 4'd1;
            if (r_bit_idx == 4'(DATA_BITS - 1)) begin
              w_state_nxt = STOP;
            end
          end
        end
        STOP: begin
          if (r_rx_cnt == w_div_last) begin
            w_rx_cnt_nxt = '0;
            w_state_nxt  = IDLE;
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_rx_cnt_nxt = '0;
        end
      endcase
    end
  end

  // The line value is captured on entry to the strobe cycle, one cycle before
  // the counter leaves it; this keeps rx_bit/done/err registered with the strobe.
  assign w_rx_tick_nxt = (w_state_nxt == DATA) && (w_rx_cnt_nxt == w_div_last);
  assign w_stop_nxt    = (w_state_nxt == STOP) && (w_rx_cnt_nxt == w_div_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_q   <= CNT_W'(DIV_RST);
      r_tx_cnt  <= '0;
      r_tx_tick <= 1'b0;
      r_clk_bps <= 1'b0;
    end else begin
      r_div_q   <= w_div_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
      r_tx_tick <= w_tx_tick_nxt;
      r_clk_bps <= w_clk_bps_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rx_cnt     <= '0;
      r_bit_idx    <= '0;
      r_rxd_d      <= 1'b1;
      r_rx_busy    <= 1'b0;
      r_rx_tick    <= 1'b0;
      r_rx_bit     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_rxd_d      <= w_rxd_c;
      r_rx_busy    <= (w_state_nxt != IDLE);
      r_rx_tick    <= w_rx_tick_nxt;
      r_frame_done <= w_stop_nxt & w_rxd_c;
      r_frame_err  <= w_stop_nxt & ~w_rxd_c;
      if (w_rx_tick_nxt) begin
        r_rx_bit <= w_rxd_c;
      end
    end
  end

  assign o_tx_tick    = r_tx_tick;
  assign o_clk_bps    = r_clk_bps;
  assign o_rx_busy    = r_rx_busy;
  assign o_rx_tick    = r_rx_tick;
  assign o_rx_bit     = r_rx_bit;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;

endmodule

// File: doc/baud_gen.md
# baud_gen

Parametrised baud-rate generator and receive bit-timing engine for the UART control path. It has a runtime-loadable divisor and a free-running transmit bit tick with a matching `clk_bps` square wave. It also re-synchronises receive timing on every start-bit falling edge and supplies mid-bit sample strobes to the shift logic. It replaces the fixed 9600-baud divider with start-edge counter reset.

## Interface
Parameters:
- `CNT_W`, 16: divisor/counter width.
- `DIV_RST`, 5208: divisor loaded at reset (clock cycles per bit).
- `DATA_BITS`, 8: data bits per frame (1..15).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: block enable.
- `div` in CNT_W: new divisor value.
- `div_load` in 1: one-cycle strobe that captures `div`.
- `rxd` in 1: asynchronous serial input (idle high).
- `tx_tick` out 1: one-cycle pulse per transmit bit period.
- `clk_bps` out 1: square wave at bit rate.
- `rx_busy` out 1: receive frame in progress.
- `rx_tick` out 1: mid-bit strobe for each data bit.
- `rx_bit` out 1: sampled data bit, valid with `rx_tick`.
- `frame_done` out 1: stop bit sampled high.
- `frame_err` out 1: stop bit sampled low.

## Operation
- Divisor register `div_q` resets to `DIV_RST`.
  - On `div_load`, `div_q` takes max(`div`, 2).
  - The same strobe clears both counters, aborts any frame with no done/err, and forces IDLE.
- Transmit counter `tx_cnt` counts 0..`div_q`-1 and wraps to 0.
  - `tx_tick`=1 in the cycle `tx_cnt`==`div_q`-1.
  - `clk_bps` is registered: high while `tx_cnt` < `div_q`>>1, low otherwise.
- Input conditioning: `rxd` goes through a two-flop synchroniser reset to 1, giving conditioned line `rxd_c`. A falling edge is `rxd_c` going 1→0 between consecutive cycles.
- Receive FSM with counter `rx_cnt` and bit counter `bit_idx`:
  - IDLE: `rx_busy`=0. On a falling edge, go to START with `rx_cnt`=0.
  - START: at `rx_cnt`==(`div_q`>>1)-1, sample `rxd_c`. If 0, go to DATA with `rx_cnt`=0 and `bit_idx`=0. If 1 (false start), go to IDLE.
  - DATA: at `rx_cnt`==`div_q`-1, pulse `rx_tick`, set `rx_bit`=`rxd_c`, increment `bit_idx` and clear `rx_cnt`. Go to STOP after the `DATA_BITS`th tick.
  - STOP: at `rx_cnt`==`div_q`-1, sample `rxd_c`. If 1, pulse `frame_done`; if 0, pulse `frame_err`. Return to IDLE.
- A falling edge is only acted on in IDLE. Edges during START, DATA or STOP are ignored.
- `en`=0 holds `tx_cnt`, forces the FSM to IDLE and zeroes all pulse outputs. `div_load` is still honoured while `en`=0.
- If `div_load` and a falling edge occur in the same cycle, `div_load` wins and the edge is dropped.

## Timing
- Reset values: all outputs 0, `tx_cnt`=`rx_cnt`=0, FSM in IDLE, synchroniser flops 1.
- `rxd` to `rxd_c` latency is 2 cycles, or 4 with the filter compiled in.
- The falling edge registers in cycle E and START begins at E+1.
- The first `rx_tick` fires at E+(`div_q`>>1)+`div_q`. Subsequent ticks follow every `div_q` cycles.
- `frame_done`/`frame_err` fires `div_q` cycles after the last `rx_tick`. IDLE is re-entered in the next cycle.
- All pulse outputs are exactly one cycle wide and are registered.
- Asserting reset mid-frame clears everything immediately. No pulse is emitted.

## Configuration
- `BAUD_GEN_RX_FILTER_EN` defined:
  - a 3-tap registered majority filter sits after the synchroniser;
  - single-cycle glitches on `rxd` never reach `rxd_c`;
  - latency is +2 cycles.
- Undefined: `rxd_c` is the synchroniser output directly. Glitches are rejected only by the START mid-bit check.

## Structure
- Package `baud_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - `DIV_MIN`=2;
  - standard divisor constants for 9600/19200/115200 baud at the board clock.
- Sub-module `baud_rx_sync` contains the synchroniser and the optional majority filter, and outputs `rxd_c`.
- The top level holds the divisor register, both counters and the FSM.

## Test plan
- Reset release with `div_load` of 16 → `tx_tick` every 16 cycles, `clk_bps` high 8 / low 8, all other outputs 0.
- Frame 0x55 sent LSB-first at 16 cycles/bit with stop=1 → 8 `rx_tick` pulses with `rx_bit` 1,0,1,0,1,0,1,0. First tick at E+24. Then `frame_done`, then `rx_busy`=0.
- `rxd` held low for 5 cycles at `div_q`=16 → START entered, rejected at the mid check, no `rx_tick`, back to IDLE.
- Same frame with stop bit 0 → 8 ticks then `frame_err`=1 and `frame_done`=0.
- `div_load` of 1 issued during DATA → `div_q`=2, frame aborted with no done/err, FSM in IDLE, `tx_tick` every 2 cycles.
- 1-cycle low glitch on `rxd`:
  - with `BAUD_GEN_RX_FILTER_EN` → no START entry;
  - without it → START entered then rejected.
